// File: rtl/lifo_stack.sv
// -----------------------------------------------------------------------------
// lifo_stack
//   Single-clock LIFO stack used by the control path to save and restore
//   return addresses and context.
//
//   Features:
//   - registered top-of-stack output
//   - occupancy count
//   - push and pop in the same cycle (replace-top)
//   - synchronous flush
//   - sticky overflow and underflow flags
//
//   Storage is a plain array, which maps to flops or distributed RAM.
//
// Configuration macro:
//   LIFO_DISCARD_OLDEST_EN
//     Defined:   storage is circular, with a bottom pointer. A push while
//                full overwrites the oldest entry and raises overflow.
//     Undefined: storage is linear from index 0. A push while full is
//                rejected and raises overflow.
//
// Parameters:
//   DATA_W     entry width in bits (>= 1)
//   LIFO_SIZE  depth in entries (>= 2, any value)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous reset, active low
//   push       write datain onto the stack
//   pop        remove the top entry
//   clear      synchronous flush of all entries (flags untouched)
//   err_clr    clear the sticky overflow/underflow flags
//   datain     data to push
//   dataout    registered top of stack, 0 when empty
//   val        stack non-empty (dataout valid)
//   full       count == LIFO_SIZE
//   count      number of stored entries
//   overflow   sticky: push while full
//   underflow  sticky: pop while empty
// -----------------------------------------------------------------------------
module lifo_stack #(
    parameter int DATA_W    = 10,
    parameter int LIFO_SIZE = 6
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           push,
    input  logic                           pop,
    input  logic                           clear,
    input  logic                           err_clr,
    input  logic [DATA_W-1:0]              datain,
    output logic [DATA_W-1:0]              dataout,
    output logic                           val,
    output logic                           full,
    output logic [$clog2(LIFO_SIZE+1)-1:0] count,
    output logic                           overflow,
    output logic                           underflow
);

    localparam int CNT_W = $clog2(LIFO_SIZE + 1);
    // Physical index width. This is never wider than CNT_W.
    localparam int IDX_W = $clog2(LIFO_SIZE);

    localparam logic [CNT_W-1:0] SIZE_C = CNT_W'(LIFO_SIZE);
    localparam logic [CNT_W:0]   SIZE_X = (CNT_W + 1)'(LIFO_SIZE);
    localparam logic [CNT_W-1:0] ONE_C  = CNT_W'(1);
    localparam logic [CNT_W-1:0] TWO_C  = CNT_W'(2);

    // -------------------------------------------------------------------------
    // Map a logical stack position to a physical slot.
    //   offset 0 = oldest entry
    //   off <= LIFO_SIZE and base < LIFO_SIZE, so one conditional subtract
    //   is enough for the wrap.
    //   One extra bit is kept so that base + off cannot overflow before
    //   the wrap is applied.
    // -------------------------------------------------------------------------
    function automatic logic [IDX_W-1:0] phys_idx(
        input logic [IDX_W-1:0] base,
        input logic [CNT_W-1:0] off
    );
        logic [CNT_W:0] sum;
        sum = (CNT_W + 1)'(base) + {1'b0, off};
        if (sum >= SIZE_X) begin
            sum = sum - SIZE_X;
        end
        return IDX_W'(sum);
    endfunction

    logic [DATA_W-1:0] mem [LIFO_SIZE];

    logic [IDX_W-1:0]  bot;
    logic [CNT_W-1:0]  count_next;
    logic [DATA_W-1:0] dout_next;
    logic              ovf_next;
    logic              udf_next;
    logic              wr_en;
    logic [IDX_W-1:0]  wr_idx;
    logic [IDX_W-1:0]  rd_idx;

    assign val  = (count != '0);
    assign full = (count == SIZE_C);

    // Slot holding the entry that becomes the new top after a pop.
    // The value is only meaningful when count >= 2.
    assign rd_idx = phys_idx(bot, count - TWO_C);

`ifdef LIFO_DISCARD_OLDEST_EN
    localparam logic [IDX_W-1:0] BOT_LAST = IDX_W'(LIFO_SIZE - 1);
    logic [IDX_W-1:0] bot_next;
`else
    // Linear storage always starts at slot 0.
    assign bot = '0;
`endif

    // -------------------------------------------------------------------------
    // Next-state decode.
    // Priority order: clear, then push&pop, then push, then pop.
    // -------------------------------------------------------------------------
    always_comb begin
        count_next = count;
        dout_next  = dataout;
        // err_clr drops the flags. A new error raised below on the same edge
        // overrides this.
        ovf_next   = err_clr ? 1'b0 : overflow;
        udf_next   = err_clr ? 1'b0 : underflow;
        wr_en      = 1'b0;
        wr_idx     = phys_idx(bot, count);
`ifdef LIFO_DISCARD_OLDEST_EN
        bot_next   = bot;
`endif

        if (clear) begin
            count_next = '0;
            dout_next  = '0;
        end else if (push && pop) begin
            // Replace the top entry in place. On an empty stack this is
            // a no-op.
            if (count != '0) begin
                wr_en     = 1'b1;
                wr_idx    = phys_idx(bot, count - ONE_C);
                dout_next = datain;
            end
        end else if (push) begin
            if (!full) begin
                wr_en      = 1'b1;
                count_next = count + ONE_C;
                dout_next  = datain;
            end else begin
                ovf_next = 1'b1;
`ifdef LIFO_DISCARD_OLDEST_EN
                // When full, the slot one past the top is the oldest entry.
                // Overwrite it and advance the bottom pointer.
                wr_en     = 1'b1;
                wr_idx    = bot;
                bot_next  = (bot == BOT_LAST) ? '0 : bot + 1'b1;
                dout_next = datain;
`endif
            end
        end else if (pop) begin
            if (count >= TWO_C) begin
                count_next = count - ONE_C;
                dout_next  = mem[rd_idx];
            end else if (count == ONE_C) begin
                count_next = '0;
                dout_next  = '0;
            end else begin
                udf_next = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count     <= '0;
            dataout   <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            count     <= count_next;
            dataout   <= dout_next;
            overflow  <= ovf_next;
            underflow <= udf_next;
        end
    end

`ifdef LIFO_DISCARD_OLDEST_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bot <= '0;
        end else begin
            bot <= bot_next;
        end
    end
`endif

    // Storage array. It is not reset; count alone decides which slots are
    // live.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_idx] <= datain;
        end
    end

endmodule

// File: tb/tb_lifo_stack.sv
// -----------------------------------------------------------------------------
// tb_lifo_stack
//   Directed self-checking bench for lifo_stack with DATA_W=10, LIFO_SIZE=6.
//   Works with or without LIFO_DISCARD_OLDEST_EN defined.
// -----------------------------------------------------------------------------
module tb_lifo_stack;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic       clear = 1'b0;
    logic       err_clr = 1'b0;
    logic [9:0] datain = '0;
    logic [9:0] dataout;
    logic       val;
    logic       full;
    logic [2:0] count;
    logic       overflow;
    logic       underflow;

    int errs = 0;
    int checks = 0;

    lifo_stack #(.DATA_W(10), .LIFO_SIZE(6)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .clear     (clear),
        .err_clr   (err_clr),
        .datain    (datain),
        .dataout   (dataout),
        .val       (val),
        .full      (full),
        .count     (count),
        .overflow  (overflow),
        .underflow (underflow)
    );

    always #5 clk = ~clk;

    // Drive one cycle of controls. Outputs are observed 1 ns after the edge.
    task automatic cycle(input logic p, input logic po, input logic c,
                         input logic e, input logic [9:0] d);
        push = p; pop = po; clear = c; err_clr = e; datain = d;
        @(posedge clk);
        #1;
        push = 1'b0; pop = 1'b0; clear = 1'b0; err_clr = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset = 1'b0;
        #2;
        checks++;
        if (count !== 3'd0 || dataout !== 10'h0) begin
            errs++;
            $display("FAIL reset_state: count=%0d dataout=%h, want 0/000", count, dataout);
        end
        checks++;
        if (val !== 1'b0 || full !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errs++;
            $display("FAIL reset_flags: val=%b full=%b ovf=%b udf=%b, want all 0",
                     val, full, overflow, underflow);
        end
        #8 reset = 1'b1;
    endtask

    task automatic test_push_full;
        logic [9:0] exp_d;
        for (int i = 1; i <= 6; i++) begin
            cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'(i));
            checks++;
            if (count !== 3'(i) || dataout !== 10'(i)) begin
                errs++;
                $display("FAIL push_%0d: count=%0d dataout=%h, want %0d/%h", i, count, dataout, i, i);
            end
        end
        checks++;
        if (full !== 1'b1 || val !== 1'b1) begin
            errs++;
            $display("FAIL full_flag: full=%b val=%b, want 1/1", full, val);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'd7);
`ifdef LIFO_DISCARD_OLDEST_EN
        exp_d = 10'd7;
`else
        exp_d = 10'd6;
`endif
        checks++;
        if (overflow !== 1'b1 || count !== 3'd6 || dataout !== exp_d) begin
            errs++;
            $display("FAIL push_when_full: ovf=%b count=%0d dataout=%h, want 1/6/%h",
                     overflow, count, dataout, exp_d);
        end
    endtask

    task automatic test_pop_to_empty;
        logic [9:0] exp_d;
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'h0);
`ifdef LIFO_DISCARD_OLDEST_EN
            exp_d = (k == 6) ? 10'd0 : 10'(7 - k);
`else
            exp_d = 10'(6 - k);
`endif
            checks++;
            if (dataout !== exp_d || count !== 3'(6 - k)) begin
                errs++;
                $display("FAIL pop_%0d: dataout=%h count=%0d, want %h/%0d",
                         k, dataout, count, exp_d, 6 - k);
            end
        end
        checks++;
        if (val !== 1'b0 || underflow !== 1'b0) begin
            errs++;
            $display("FAIL empty_state: val=%b udf=%b, want 0/0", val, underflow);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'h0);
        checks++;
        if (underflow !== 1'b1 || count !== 3'd0 || dataout !== 10'h0) begin
            errs++;
            $display("FAIL pop_when_empty: udf=%b count=%0d dataout=%h, want 1/0/000",
                     underflow, count, dataout);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h0);
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0) begin
            errs++;
            $display("FAIL err_clr: ovf=%b udf=%b, want 0/0", overflow, underflow);
        end
    endtask

    task automatic test_replace_top;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'h03A);
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'h015);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'h2FF);
        checks++;
        if (count !== 3'd2 || dataout !== 10'h2FF || overflow !== 1'b0 || underflow !== 1'b0) begin
            errs++;
            $display("FAIL replace_top: count=%0d dataout=%h ovf=%b udf=%b, want 2/2ff/0/0",
                     count, dataout, overflow, underflow);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'h0);
        checks++;
        if (count !== 3'd1 || dataout !== 10'h03A) begin
            errs++;
            $display("FAIL pop_after_replace: count=%0d dataout=%h, want 1/03a", count, dataout);
        end
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'h0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0, 10'h011);
        checks++;
        if (count !== 3'd0 || dataout !== 10'h0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errs++;
            $display("FAIL pushpop_empty: count=%0d dataout=%h ovf=%b udf=%b, want 0/000/0/0",
                     count, dataout, overflow, underflow);
        end
    endtask

    task automatic test_clear_errclr;
        for (int i = 1; i <= 3; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'(i));
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 10'h077);
        checks++;
        if (count !== 3'd0 || dataout !== 10'h0 || val !== 1'b0) begin
            errs++;
            $display("FAIL clear_over_push: count=%0d dataout=%h val=%b, want 0/000/0",
                     count, dataout, val);
        end
        for (int i = 1; i <= 6; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'(10'h100 + i));
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'h1FF);
        checks++;
        if (overflow !== 1'b1) begin
            errs++;
            $display("FAIL overflow_set: ovf=%b, want 1", overflow);
        end
        cycle(1'b1, 1'b0, 1'b0, 1'b1, 10'h1FE);
        checks++;
        if (overflow !== 1'b1 || count !== 3'd6) begin
            errs++;
            $display("FAIL errclr_vs_new_ovf: ovf=%b count=%0d, want 1/6", overflow, count);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h0);
        checks++;
        if (overflow !== 1'b0 || count !== 3'd6) begin
            errs++;
            $display("FAIL errclr_alone: ovf=%b count=%0d, want 0/6", overflow, count);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 10'h0);
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'h0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 10'h0);
        checks++;
        if (underflow !== 1'b1 || count !== 3'd0) begin
            errs++;
            $display("FAIL clear_keeps_flag: udf=%b count=%0d, want 1/0", underflow, count);
        end
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 10'h0);
        checks++;
        if (underflow !== 1'b0) begin
            errs++;
            $display("FAIL udf_clr: udf=%b, want 0", underflow);
        end
    endtask

    task automatic test_async_reset;
        cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'h0);
        for (int i = 1; i <= 4; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'(10'h200 + i));
        checks++;
        if (count !== 3'd4 || dataout !== 10'h204 || underflow !== 1'b1) begin
            errs++;
            $display("FAIL pre_reset: count=%0d dataout=%h udf=%b, want 4/204/1",
                     count, dataout, underflow);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (count !== 3'd0 || dataout !== 10'h0 || val !== 1'b0 || underflow !== 1'b0 || overflow !== 1'b0) begin
            errs++;
            $display("FAIL async_reset: count=%0d dataout=%h val=%b udf=%b ovf=%b, want all 0",
                     count, dataout, val, underflow, overflow);
        end
        #4 reset = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'h055);
        checks++;
        if (count !== 3'd1 || dataout !== 10'h055) begin
            errs++;
            $display("FAIL push_after_reset: count=%0d dataout=%h, want 1/055", count, dataout);
        end
    endtask

`ifdef LIFO_DISCARD_OLDEST_EN
    task automatic test_discard_oldest;
        logic [9:0] exp_d;
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 10'h0);
        for (int i = 1; i <= 8; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0, 10'(i));
        checks++;
        if (count !== 3'd6 || overflow !== 1'b1 || dataout !== 10'd8) begin
            errs++;
            $display("FAIL discard_fill: count=%0d ovf=%b dataout=%h, want 6/1/008",
                     count, overflow, dataout);
        end
        for (int k = 1; k <= 6; k++) begin
            cycle(1'b0, 1'b1, 1'b0, 1'b0, 10'h0);
            exp_d = (k == 6) ? 10'd0 : 10'(8 - k);
            checks++;
            if (dataout !== exp_d) begin
                errs++;
                $display("FAIL discard_pop_%0d: dataout=%h, want %h", k, dataout, exp_d);
            end
        end
        checks++;
        if (val !== 1'b0) begin
            errs++;
            $display("FAIL discard_empty: val=%b, want 0", val);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_push_full;
        test_pop_to_empty;
        test_replace_top;
        test_clear_errclr;
        test_async_reset;
`ifdef LIFO_DISCARD_OLDEST_EN
        test_discard_oldest;
`endif
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
